// File: rtl/pc_fetch_sequencer.sv
// Fetch-stage controller: owns the PC, runs the imem req/ack handshake, buffers one
// instruction for decode and selects the next PC (seq / branch / J / JR) on accept.
module pc_fetch_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000,
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic        clk_i,
    input  logic        reset_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    input  logic        stall_i,
    input  logic        br_taken_i,
    input  logic [15:0] br_imm_i,
    input  logic        j_en_i,
    input  logic [25:0] j_index_i,
    input  logic        jr_en_i,
    input  logic [31:0] jr_addr_i,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    output logic        instr_valid_o,
    output logic        fetch_err_o
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_REQ  = 2'd1,
        ST_FULL = 2'd2,
        ST_ERR  = 2'd3
    } state_e;

    // The counter only has to reach MAX_WAIT-1, the index of the last permitted req cycle.
    localparam int CNT_W = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

    state_e            state_q;
    logic [CNT_W-1:0]  wait_cnt_q;
    logic [31:0]       pc_q;
    logic [31:0]       instr_q;
    logic [31:0]       instr_pc_q;
    logic              imem_req_q;
    logic              instr_valid_q;
    logic              fetch_err_q;

    logic [31:0]       seq_pc_s;
    logic [31:0]       br_off_s;
    logic [31:0]       jr_target_s;
    logic [31:0]       next_pc_d;
    logic              accept_s;

    assign seq_pc_s    = instr_pc_q + 32'd4;
    assign br_off_s    = {{14{br_imm_i[15]}}, br_imm_i, 2'b00};
    assign jr_target_s = jr_addr_i & ~32'd3;
    assign accept_s    = instr_valid_q & ~stall_i;

    // Next-PC select, only consumed on the accept cycle; jr > j > branch > sequential.
    always_comb begin
        next_pc_d = seq_pc_s;
        if (jr_en_i) begin
            next_pc_d = jr_target_s;
        end else if (j_en_i) begin
            next_pc_d = {seq_pc_s[31:28], j_index_i, 2'b00};
        end else if (br_taken_i) begin
            next_pc_d = seq_pc_s + br_off_s;
        end else begin
            next_pc_d = seq_pc_s;
        end
    end

    // Fetch FSM with all outputs registered; pc_q doubles as the held fetch address.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q       <= ST_BOOT;
            wait_cnt_q    <= '0;
            pc_q          <= RESET_PC;
            instr_q       <= 32'h0000_0000;
            instr_pc_q    <= 32'h0000_0000;
            imem_req_q    <= 1'b0;
            instr_valid_q <= 1'b0;
            fetch_err_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q    <= ST_REQ;
                    wait_cnt_q <= '0;
                    imem_req_q <= 1'b1;
                end
                ST_REQ: begin
                    if (imem_ack_i) begin
                        instr_q       <= imem_rdata_i;
                        instr_pc_q    <= pc_q;
                        imem_req_q    <= 1'b0;
                        instr_valid_q <= 1'b1;
                        state_q       <= ST_FULL;
                    end else if (wait_cnt_q == CNT_LAST) begin
                        imem_req_q  <= 1'b0;
                        fetch_err_q <= 1'b1;
                        state_q     <= ST_ERR;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + CNT_W'(1);
                    end
                end
                ST_FULL: begin
                    if (accept_s) begin
                        pc_q          <= next_pc_d;
                        wait_cnt_q    <= '0;
                        imem_req_q    <= 1'b1;
                        instr_valid_q <= 1'b0;
                        state_q       <= ST_REQ;
                    end else begin
                        state_q <= ST_FULL;
                    end
                end
                ST_ERR: begin
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                    fetch_err_q   <= 1'b1;
                    state_q       <= ST_ERR;
                end
                default: begin
                    imem_req_q    <= 1'b0;
                    instr_valid_q <= 1'b0;
                    state_q       <= ST_BOOT;
                end
            endcase
        end
    end

    assign imem_req_o    = imem_req_q;
    assign imem_addr_o   = pc_q;
    assign instr_o       = instr_q;
    assign instr_pc_o    = instr_pc_q;
    assign instr_valid_o = instr_valid_q;
    assign fetch_err_o   = fetch_err_q;

endmodule
